// File: rtl/pixel_ctrl_pkg.sv
// pixel_ctrl_pkg: shared FSM states, default bus width and Gray-code helpers for the pixel readout controller
package pixel_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, TURN, READ, HOLD} state_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended inputs decode unchanged.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b ^= b >> 1;
        b ^= b >> 2;
        b ^= b >> 4;
        b ^= b >> 8;
        b ^= b >> 16;
        return b;
    endfunction

endpackage

// File: rtl/pixel_conv_counter.sv
// pixel_conv_counter: ramp phase and code-step counter for the CONVERT window
//  clk, reset : clock, synchronous active-high reset
//  en         : high while the sequencer sits in CONVERT
//  ramp       : comparator ramp clock (registered phase bit)
//  count      : current code step, 0..CONV_STEPS-1
//  done       : last cycle of the conversion window
module pixel_conv_counter
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned CONV_STEPS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic              ramp,
    output logic [DATA_W-1:0] count,
    output logic              done
);

    localparam logic [DATA_W-1:0] LAST = DATA_W'(CONV_STEPS - 1);

    logic              phase_q, phase_d;
    logic [DATA_W-1:0] count_q, count_d;

    // Count advances only on the ramp falling edge, so the code is stable
    // across every rising edge; clearing on done keeps it from wrapping.
    always_comb begin
        done    = en && phase_q && count_q == LAST;
        phase_d = en && !phase_q;
        count_d = (!en || done) ? '0 : count_q + DATA_W'(phase_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
            count_q <= '0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
        end
    end

    assign ramp  = phase_q;
    assign count = count_q;

endmodule

// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl: erase/expose/convert/read sequencer for one digital pixel with valid/ready result
//  clk, reset          : clock, synchronous active-high reset
//  start               : one-cycle run request, honoured only in IDLE
//  busy                : high outside IDLE
//  erase/expose/ramp/read : pixel strobes
//  data_out, data_oe   : code driven onto the shared bus during CONVERT
//  data_in             : bus value, sampled on the final READ cycle
//  pix_data, pix_valid, pix_ready : captured code and handshake
//  Build option GRAY_CODE_EN: Gray-coded bus codes, decoded back to binary on capture.
module pixel_readout_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned ERASE_CYCLES  = 5,
    parameter int unsigned EXPOSE_CYCLES = 255,
    parameter int unsigned CONV_STEPS    = 256,
    parameter int unsigned READ_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              erase,
    output logic              expose,
    output logic              ramp,
    output logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready
);

    localparam int unsigned DUR_EX  = EXPOSE_CYCLES > ERASE_CYCLES ? EXPOSE_CYCLES : ERASE_CYCLES;
    localparam int unsigned DUR_MAX = DUR_EX > READ_CYCLES ? DUR_EX : READ_CYCLES;
    localparam int unsigned DUR_W   = $clog2(DUR_MAX + 1);
    localparam logic [DUR_W-1:0] ERASE_LAST  = DUR_W'(ERASE_CYCLES - 1);
    localparam logic [DUR_W-1:0] EXPOSE_LAST = DUR_W'(EXPOSE_CYCLES - 1);
    localparam logic [DUR_W-1:0] READ_LAST   = DUR_W'(READ_CYCLES - 1);

    state_e            state_q, state_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              conv_done, capture;
    logic [DATA_W-1:0] count, bus_code, pix_q;
    logic              busy_q, erase_q, expose_q, oe_q, read_q, valid_q;

    pixel_conv_counter #(
        .DATA_W    (DATA_W),
        .CONV_STEPS(CONV_STEPS)
    ) u_conv (
        .clk  (clk),
        .reset(reset),
        .en   (state_q == CONVERT),
        .ramp (ramp),
        .count(count),
        .done (conv_done)
    );

`ifdef GRAY_CODE_EN
    assign data_out = DATA_W'(bin2gray(32'(count)));
    assign bus_code = DATA_W'(gray2bin(32'(data_in)));
`else
    assign data_out = count;
    assign bus_code = data_in;
`endif

    // dur counts cycles spent in the current timed state and restarts at 0 on every transition.
    always_comb begin
        state_d = state_q;
        dur_d   = '0;
        capture = state_q == READ && dur_q == READ_LAST;
        case (state_q)
            IDLE:    state_d = start ? ERASE : IDLE;
            ERASE:   if (dur_q == ERASE_LAST) state_d = EXPOSE; else dur_d = dur_q + DUR_W'(1);
            EXPOSE:  if (dur_q == EXPOSE_LAST) state_d = CONVERT; else dur_d = dur_q + DUR_W'(1);
            CONVERT: state_d = conv_done ? TURN : CONVERT;
            TURN:    state_d = READ;
            READ:    if (capture) state_d = HOLD; else dur_d = dur_q + DUR_W'(1);
            HOLD:    state_d = pix_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up exactly with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            dur_q    <= '0;
            busy_q   <= 1'b0;
            erase_q  <= 1'b0;
            expose_q <= 1'b0;
            oe_q     <= 1'b0;
            read_q   <= 1'b0;
            valid_q  <= 1'b0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            dur_q    <= dur_d;
            busy_q   <= state_d != IDLE;
            erase_q  <= state_d == ERASE;
            expose_q <= state_d == EXPOSE;
            oe_q     <= state_d == CONVERT;
            read_q   <= state_d == READ;
            valid_q  <= state_d == HOLD;
            if (capture) pix_q <= bus_code;
        end
    end

    assign busy      = busy_q;
    assign erase     = erase_q;
    assign expose    = expose_q;
    assign data_oe   = oe_q;
    assign read      = read_q;
    assign pix_valid = valid_q;
    assign pix_data  = pix_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// tb_pixel_readout_ctrl: scoreboard bench with a behavioural pixel on the shared bus
module tb_pixel_readout_ctrl;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, pix_ready = 1'b0;
    logic       busy, erase, expose, ramp, read, data_oe, pix_valid;
    logic [7:0] data_out, data_in, pix_data;
    logic [7:0] latch = 8'h00;
    int         vectors = 0, miscompares = 0;
    int         exp_q[$];
    int         trip = 1000;

    always #5 clk = ~clk;

    // Shared bus: controller drives during conversion, pixel during read, idle low otherwise.
    assign data_in = data_oe ? data_out : read ? latch : 8'h00;

    pixel_readout_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .erase    (erase),
        .expose   (expose),
        .ramp     (ramp),
        .read     (read),
        .data_out (data_out),
        .data_oe  (data_oe),
        .data_in  (data_in),
        .pix_data (pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel: the k-th ramp rising edge carries code k; the latch follows the bus until the comparator trips at code == trip.
    int   k = 0;
    logic tripped = 1'b0, pr = 1'b0;
    always @(negedge clk) begin
        if (erase) begin
            k = 0;
            tripped = 1'b0;
            latch = 8'h00;
        end else if (ramp && !pr) begin
            if (!tripped) latch = data_out;
            if (k == trip) tripped = 1'b1;
            k++;
        end
        pr = ramp;
    end

    // Monitor: per-run strobe statistics and result check against the scoreboard.
    int   n_erase = 0, n_expose = 0, n_oe = 0, n_rise = 0, n_read = 0, n_gap = 0, n_pre = 0;
    logic ramp_p = 1'b0, oe_p = 1'b0;
    always @(negedge clk) begin
        chk("oe_read_exclusive", int'(data_oe && read), 0);
        if (ramp !== ramp_p) chk("ramp_outside_convert", int'(oe_p), 1);
        if (reset) begin
            n_erase = 0; n_expose = 0; n_oe = 0; n_rise = 0; n_read = 0; n_gap = 0; n_pre = 0;
        end else begin
            n_erase  += int'(erase);
            n_expose += int'(expose);
            n_oe     += int'(data_oe);
            n_read   += int'(read);
            n_rise   += int'(ramp && !ramp_p);
            n_gap    += int'(busy && !erase && !expose && !data_oe && !read && !pix_valid);
            n_pre    += int'(busy && !pix_valid);
            if (pix_valid) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    chk("pix_data", int'(pix_data), exp_q[0]);
                    if (pix_ready) begin
                        exp_q.delete(0);
                        chk("erase_cycles", n_erase, 5);
                        chk("expose_cycles", n_expose, 255);
                        chk("convert_cycles", n_oe, 512);
                        chk("ramp_steps", n_rise, 256);
                        chk("turn_cycles", n_gap, 1);
                        chk("read_cycles", n_read, 4);
                        chk("busy_cycles", n_pre, 777);
                        n_erase = 0; n_expose = 0; n_oe = 0; n_rise = 0; n_read = 0; n_gap = 0; n_pre = 0;
                    end
                end
            end
        end
        ramp_p = ramp;
        oe_p   = data_oe;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_erase"}, int'(erase), 0);
        chk({tag, "_expose"}, int'(expose), 0);
        chk({tag, "_ramp"}, int'(ramp), 0);
        chk({tag, "_read"}, int'(read), 0);
        chk({tag, "_data_oe"}, int'(data_oe), 0);
        chk({tag, "_data_out"}, int'(data_out), 0);
        chk({tag, "_pix_valid"}, int'(pix_valid), 0);
        chk({tag, "_pix_data"}, int'(pix_data), 0);
    endtask

    task automatic run(input int t, input int hold);
        int i;
        trip = t;
        pix_ready = (hold == 0);
        exp_q.push_back(t < 256 ? t : 255);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("erase_after_start", int'(erase), 1);
        i = 0;
        while (!pix_valid && i < 1000) begin
            tick;
            i++;
        end
        chk("valid_timeout", int'(pix_valid), 1);
        for (int h = 0; h < hold; h++) begin
            start = (h % 2 == 0);
            tick;
            chk("hold_valid", int'(pix_valid), 1);
            chk("hold_busy", int'(busy), 1);
        end
        start = 1'b0;
        pix_ready = 1'b1;
        tick;
        pix_ready = 1'b0;
        chk("accept_valid_low", int'(pix_valid), 0);
        chk("accept_busy_low", int'(busy), 0);
        tick;
        tick;
        chk("no_queued_start", int'(erase), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i;
        repeat (3) tick;
        check_idle("reset");
        reset = 1'b0;
        tick;
        run(100, 20);
        run(1000, 0);
        // Abort in the middle of conversion.
        trip = 1000;
        exp_q.push_back(255);
        start = 1'b1;
        tick;
        start = 1'b0;
        i = 0;
        while (!data_oe && i < 1000) begin
            tick;
            i++;
        end
        repeat (80) tick;
        chk("abort_in_convert", int'(data_oe), 1);
        reset = 1'b1;
        exp_q.delete(exp_q.size() - 1);
        tick;
        check_idle("abort");
        reset = 1'b0;
        tick;
        run(77, 3);
        run(0, 1);
        for (int r = 0; r < 4; r++) run(int'($urandom_range(0, 300)), int'($urandom_range(0, 4)));
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
